branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Sits directly downstream of the 32-bit magnitude comparator in the MIPS32 execute stage.
- Consumes the comparator's Gt/Eq/Lt flags plus the sign bit of operand A, and resolves the conditional branch op.
- On a taken branch, computes the target and issues a redirect to fetch over a valid/ready handshake, then pulses a pipeline flush.
- Reports a one-cycle resolution result for every accepted branch, taken or not.

Parameters:
- ADDR_W, 32, width of PC and target.
- IMM_W, 16, width of the branch offset immediate in words.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- br_valid_i  in  1  branch op presented.
- br_ready_o  out  1  unit can accept a branch.
- br_op_i  in  3  000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 110/111 reserved.
- pc_plus4_i  in  ADDR_W  PC of branch + 4.
- imm_i  in  IMM_W  signed word offset.
- cmp_gt_i, cmp_eq_i, cmp_lt_i  in  1 each  unsigned comparator flags. B is rt for BEQ/BNE and 0 for zero-compare ops.
- sign_a_i  in  1  bit 31 of operand A (rs).
- res_valid_o  out  1  one-cycle pulse: branch resolved.
- res_taken_o  out  1  decision, valid with res_valid_o.
- illegal_o  out  1  one-cycle pulse: reserved op accepted.
- redir_valid_o  out  1  redirect request to fetch.
- redir_ready_i  in  1  fetch accepts redirect.
- redir_target_o  out  ADDR_W  branch target.
- flush_o  out  1  one-cycle flush of younger stages.

Behaviour:
- Reset state and values:
  - FSM reset state is IDLE; all outputs reset to 0 except br_ready_o, which is 1 because it is driven from IDLE.
  - reset_n low at any point, including mid-REDIRECT, returns to IDLE immediately. The pending redirect is dropped; no flush is issued.
- FSM states: IDLE, REDIRECT, FLUSH. br_ready_o = (state == IDLE).
- IDLE: accept when br_valid_i && br_ready_o (cycle N). Decision is evaluated combinationally from inputs at N:
  - BEQ: eq.
  - BNE: !eq.
  - BLEZ: sign_a | eq.
  - BGTZ: !sign_a & gt.
  - BLTZ: sign_a.
  - BGEZ: !sign_a.
  - Reserved ops: not-taken, and illegal_o pulses at N+1.
  - cmp_lt_i is ignored for the zero-compare ops.
- Registered at N+1:
  - res_valid_o = 1 and res_taken_o = decision, both for exactly one cycle.
  - Taken: redir_target_o = pc_plus4_i + (sign-extended imm_i << 2), modulo 2^ADDR_W (wrap-around, no overflow flag); redir_valid_o = 1; state goes to REDIRECT.
  - Not taken: state stays IDLE, so back-to-back accepts at N and N+1 are allowed.
- REDIRECT:
  - Hold redir_valid_o = 1; redir_target_o stays stable until handshake.
  - On redir_valid_o && redir_ready_i at cycle M: go to FLUSH. redir_valid_o = 0 and flush_o = 1 at M+1.
  - If redir_ready_i is already high at N+1, the handshake completes at N+1.
- FLUSH: flush_o = 1 for that single cycle, then return to IDLE. br_ready_o is 0 in FLUSH.
- Minimum taken-branch occupancy is 3 cycles (N, N+1, N+2). Inputs are ignored while br_ready_o = 0.
- redir_target_o holds its last value when redir_valid_o = 0.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs stat_taken_o[31:0] and stat_nottaken_o[31:0]. Each increments at the res_valid_o cycle per decision, wraps from 0xFFFFFFFF to 0, and resets to 0 on reset_n.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- BEQ, eq=1, pc_plus4=0x00400004, imm=0x0003, redir_ready_i=1 -> N+1: res_taken=1, redir_valid=1, target=0x00400010; N+2: flush_o=1; N+3: br_ready_o=1.
- BLTZ with sign_a=1, then BGEZ with sign_a=1 back-to-back, imm=0xFFFF -> first: taken, target=pc_plus4-4. Second is accepted only after FLUSH and resolves not-taken with no redirect.
- BGTZ with gt=1, sign_a=0, redir_ready_i held 0 for 5 cycles -> redir_valid_o and target stable for all 5 cycles, br_ready_o=0, flush_o pulses once, one cycle after ready rises.
- Target wrap: pc_plus4=0xFFFFFFFC, imm=0x0002 -> target=0x00000004.
- br_op_i=110 -> illegal_o=1 and res_taken_o=0 at N+1, no redirect. reset_n asserted in REDIRECT -> redir_valid_o=0 at once, no flush_o, br_ready_o=1.
- With BRANCH_STATS_EN: 3 taken and 2 not-taken branches -> stat_taken_o=3, stat_nottaken_o=2. Preload 0xFFFFFFFF, then one taken -> stat_taken_o=0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves MIPS32 conditional branches from the magnitude comparator's flags.
//   Every accepted branch produces a one-cycle result. A taken branch also
//   sends a redirect to fetch over a valid/ready handshake and then pulses a
//   flush of the younger pipeline stages.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   br_valid_i/br_ready_o branch op handshake (ready only in IDLE)
//   br_op_i               000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ,
//                         101 BGEZ, 11x reserved
//   pc_plus4_i, imm_i     branch PC+4 and signed word offset
//   cmp_gt/eq/lt_i        unsigned comparator flags; sign_a_i = rs[31]
//   res_valid_o/res_taken_o  one-cycle resolution result
//   illegal_o             one-cycle pulse when a reserved op is accepted
//   redir_valid_o/redir_ready_i/redir_target_o  redirect to fetch
//   flush_o               one-cycle flush after the redirect handshake
//
// Optional feature: define BRANCH_STATS_EN to add stat_taken_o and
// stat_nottaken_o, 32-bit wrapping counters of resolved branches.

module branch_resolve_unit #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  logic [2:0]        br_op_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic              cmp_gt_i,
    input  logic              cmp_eq_i,
    input  logic              cmp_lt_i,
    input  logic              sign_a_i,
    output logic              res_valid_o,
    output logic              res_taken_o,
    output logic              illegal_o,
    output logic              redir_valid_o,
    input  logic              redir_ready_i,
    output logic [ADDR_W-1:0] redir_target_o,
    output logic              flush_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       stat_taken_o,
    output logic [31:0]       stat_nottaken_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLEZ = 3'b010;
    localparam logic [2:0] OP_BGTZ = 3'b011;
    localparam logic [2:0] OP_BLTZ = 3'b100;
    localparam logic [2:0] OP_BGEZ = 3'b101;

    state_t            state, state_n;
    logic              accept;
    logic              taken;
    logic              reserved;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] offset;

    // The zero-compare ops decide on sign and gt/eq alone, so lt is never
    // needed; the name keeps it out of the unused-signal lint.
    logic              unused_cmp_lt;
    assign unused_cmp_lt = cmp_lt_i;

    assign accept = br_valid_i && (state == IDLE);

    // Branch decision, purely combinational from the presented op and flags.
    always_comb begin
        taken    = 1'b0;
        reserved = 1'b0;
        case (br_op_i)
            OP_BEQ:  taken = cmp_eq_i;
            OP_BNE:  taken = !cmp_eq_i;
            OP_BLEZ: taken = sign_a_i | cmp_eq_i;
            OP_BGTZ: taken = !sign_a_i & cmp_gt_i;
            OP_BLTZ: taken = sign_a_i;
            OP_BGEZ: taken = !sign_a_i;
            default: reserved = 1'b1;
        endcase
    end

    // Word offset sign-extended to byte offset; the add wraps modulo 2^ADDR_W.
    assign offset = {{(ADDR_W-IMM_W-2){imm_i[IMM_W-1]}}, imm_i, 2'b00};
    assign target = pc_plus4_i + offset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n       = state;
        br_ready_o    = 1'b0;
        redir_valid_o = 1'b0;
        flush_o       = 1'b0;
        case (state)
            IDLE: begin
                br_ready_o = 1'b1;
                if (accept && taken) state_n = REDIRECT;
            end
            REDIRECT: begin
                redir_valid_o = 1'b1;
                if (redir_ready_i) state_n = FLUSH;
            end
            FLUSH: begin
                flush_o = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Result pulses; the target register only loads on a taken accept so it
    // is stable through REDIRECT and keeps its last value afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid_o    <= 1'b0;
            res_taken_o    <= 1'b0;
            illegal_o      <= 1'b0;
            redir_target_o <= '0;
        end else begin
            res_valid_o <= accept;
            res_taken_o <= accept && taken;
            illegal_o   <= accept && reserved;
            if (accept && taken) redir_target_o <= target;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_taken_o    <= '0;
            stat_nottaken_o <= '0;
        end else if (accept) begin
            if (taken) stat_taken_o    <= stat_taken_o + 32'd1;
            else       stat_nottaken_o <= stat_nottaken_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a vector table covering every op
// decision, offset sign and target wrap, plus hand sequences for the
// back-to-back, stalled-redirect and reset-during-redirect cases.

module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        br_valid_i;
    logic        br_ready_o;
    logic [2:0]  br_op_i;
    logic [31:0] pc_plus4_i;
    logic [15:0] imm_i;
    logic        cmp_gt_i, cmp_eq_i, cmp_lt_i, sign_a_i;
    logic        res_valid_o, res_taken_o, illegal_o;
    logic        redir_valid_o, redir_ready_i;
    logic [31:0] redir_target_o;
    logic        flush_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken_o, stat_nottaken_o;
`endif

    branch_resolve_unit #(.ADDR_W(32), .IMM_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .br_valid_i     (br_valid_i),
        .br_ready_o     (br_ready_o),
        .br_op_i        (br_op_i),
        .pc_plus4_i     (pc_plus4_i),
        .imm_i          (imm_i),
        .cmp_gt_i       (cmp_gt_i),
        .cmp_eq_i       (cmp_eq_i),
        .cmp_lt_i       (cmp_lt_i),
        .sign_a_i       (sign_a_i),
        .res_valid_o    (res_valid_o),
        .res_taken_o    (res_taken_o),
        .illegal_o      (illegal_o),
        .redir_valid_o  (redir_valid_o),
        .redir_ready_i  (redir_ready_i),
        .redir_target_o (redir_target_o),
        .flush_o        (flush_o)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken_o   (stat_taken_o),
        .stat_nottaken_o(stat_nottaken_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        eq, gt, lt, sign;
        logic [31:0] pc;
        logic [15:0] imm;
        logic        exp_taken;
        logic        exp_ill;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[16];
    int   nchk  = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        br_valid_i = 1'b1;
        br_op_i    = v.op;
        cmp_eq_i   = v.eq;
        cmp_gt_i   = v.gt;
        cmp_lt_i   = v.lt;
        sign_a_i   = v.sign;
        pc_plus4_i = v.pc;
        imm_i      = v.imm;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic eq, input logic gt,
                            input logic sign, input logic [31:0] pc, input logic [15:0] imm);
        br_valid_i = 1'b1;
        br_op_i    = op;
        cmp_eq_i   = eq;
        cmp_gt_i   = gt;
        cmp_lt_i   = !eq && !gt;
        sign_a_i   = sign;
        pc_plus4_i = pc;
        imm_i      = imm;
    endtask

    // One branch with fetch always ready; all checks on the falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(v);
        redir_ready_i = 1'b1;
        @(negedge clk);                                   // N+1
        br_valid_i = 1'b0;
        chk({s, ".res_valid"}, 32'(res_valid_o), 32'd1);
        chk({s, ".res_taken"}, 32'(res_taken_o), 32'(v.exp_taken));
        chk({s, ".illegal"},   32'(illegal_o),   32'(v.exp_ill));
        chk({s, ".redir_valid"}, 32'(redir_valid_o), 32'(v.exp_taken));
        if (v.exp_taken) chk({s, ".target"}, redir_target_o, v.exp_tgt);
        @(negedge clk);                                   // N+2
        chk({s, ".res_valid_n2"}, 32'(res_valid_o), 32'd0);
        chk({s, ".illegal_n2"},   32'(illegal_o),   32'd0);
        chk({s, ".flush_n2"},     32'(flush_o),     32'(v.exp_taken));
        chk({s, ".ready_n2"},     32'(br_ready_o),  32'(!v.exp_taken));
        if (v.exp_taken) begin
            @(negedge clk);                               // N+3
            chk({s, ".ready_n3"}, 32'(br_ready_o), 32'd1);
            chk({s, ".flush_n3"}, 32'(flush_o),    32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        //          op     eq gt lt sg  pc            imm       tk ill target
        vecs[0]  = '{3'b000, 1, 0, 0, 0, 32'h00400004, 16'h0003, 1, 0, 32'h00400010};
        vecs[1]  = '{3'b000, 0, 1, 0, 0, 32'h00400004, 16'h0003, 0, 0, 32'h0};
        vecs[2]  = '{3'b001, 0, 0, 1, 0, 32'h00001000, 16'hFFFE, 1, 0, 32'h00000FF8};
        vecs[3]  = '{3'b001, 1, 0, 0, 0, 32'h00001000, 16'h0001, 0, 0, 32'h0};
        vecs[4]  = '{3'b010, 0, 1, 0, 1, 32'h00002000, 16'h0010, 1, 0, 32'h00002040};
        vecs[5]  = '{3'b010, 1, 0, 0, 0, 32'h00002000, 16'h0000, 1, 0, 32'h00002000};
        vecs[6]  = '{3'b010, 0, 1, 0, 0, 32'h00002000, 16'h0004, 0, 0, 32'h0};
        vecs[7]  = '{3'b011, 0, 1, 0, 0, 32'hFFFFFFFC, 16'h0002, 1, 0, 32'h00000004};
        vecs[8]  = '{3'b011, 0, 1, 0, 1, 32'h00003000, 16'h0002, 0, 0, 32'h0};
        vecs[9]  = '{3'b011, 1, 0, 0, 0, 32'h00003000, 16'h0002, 0, 0, 32'h0};
        vecs[10] = '{3'b100, 0, 1, 0, 1, 32'h00000100, 16'hFFFF, 1, 0, 32'h000000FC};
        vecs[11] = '{3'b100, 0, 0, 1, 0, 32'h00000100, 16'hFFFF, 0, 0, 32'h0};
        vecs[12] = '{3'b101, 1, 0, 0, 0, 32'h00000000, 16'h7FFF, 1, 0, 32'h0001FFFC};
        vecs[13] = '{3'b101, 0, 1, 0, 1, 32'h00000000, 16'h0001, 0, 0, 32'h0};
        vecs[14] = '{3'b110, 1, 0, 0, 0, 32'h00005000, 16'h0001, 0, 1, 32'h0};
        vecs[15] = '{3'b111, 0, 0, 0, 1, 32'h00005000, 16'h0001, 0, 1, 32'h0};

        reset_n       = 1'b0;
        br_valid_i    = 1'b0;
        br_op_i       = 3'b000;
        pc_plus4_i    = '0;
        imm_i         = '0;
        cmp_gt_i      = 1'b0;
        cmp_eq_i      = 1'b0;
        cmp_lt_i      = 1'b0;
        sign_a_i      = 1'b0;
        redir_ready_i = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.ready",       32'(br_ready_o),    32'd1);
        chk("rst.res_valid",   32'(res_valid_o),   32'd0);
        chk("rst.res_taken",   32'(res_taken_o),   32'd0);
        chk("rst.illegal",     32'(illegal_o),     32'd0);
        chk("rst.redir_valid", 32'(redir_valid_o), 32'd0);
        chk("rst.target",      redir_target_o,     32'd0);
        chk("rst.flush",       32'(flush_o),       32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Back-to-back not-taken accepts
        @(negedge clk);
        drive_op(3'b001, 1, 0, 0, 32'h100, 16'h1);        // BNE not taken
        redir_ready_i = 1'b1;
        @(negedge clk);
        chk("b2b.res_valid1", 32'(res_valid_o), 32'd1);
        chk("b2b.ready1",     32'(br_ready_o),  32'd1);
        drive_op(3'b000, 0, 1, 0, 32'h100, 16'h1);        // BEQ not taken
        @(negedge clk);
        br_valid_i = 1'b0;
        chk("b2b.res_valid2", 32'(res_valid_o), 32'd1);
        chk("b2b.taken2",     32'(res_taken_o), 32'd0);
        @(negedge clk);
        chk("b2b.res_valid3", 32'(res_valid_o), 32'd0);

        // BLTZ taken, BGEZ held valid behind it: accepted only after FLUSH
        drive_op(3'b100, 0, 1, 1, 32'h00000500, 16'hFFFF);
        redir_ready_i = 1'b1;
        @(negedge clk);                                   // N+1
        chk("seq.taken1",  32'(res_taken_o), 32'd1);
        chk("seq.target1", redir_target_o,   32'h000004FC);
        drive_op(3'b101, 0, 1, 1, 32'h00000600, 16'h0008);
        @(negedge clk);                                   // N+2 (FLUSH)
        chk("seq.flush",     32'(flush_o),     32'd1);
        chk("seq.ready_fl",  32'(br_ready_o),  32'd0);
        chk("seq.resv_fl",   32'(res_valid_o), 32'd0);
        @(negedge clk);                                   // N+3 IDLE, accepts BGEZ
        chk("seq.ready_n3",  32'(br_ready_o),  32'd1);
        chk("seq.resv_n3",   32'(res_valid_o), 32'd0);
        @(negedge clk);
        br_valid_i = 1'b0;
        chk("seq.resv2",     32'(res_valid_o),   32'd1);
        chk("seq.taken2",    32'(res_taken_o),   32'd0);
        chk("seq.redir2",    32'(redir_valid_o), 32'd0);
        chk("seq.tgt_hold",  redir_target_o,     32'h000004FC);
        @(negedge clk);
        chk("seq.flush2",    32'(flush_o),       32'd0);

        // BGTZ with fetch stalled for 5 cycles
        drive_op(3'b011, 0, 1, 0, 32'h00008000, 16'h0004);
        redir_ready_i = 1'b0;
        @(negedge clk);
        br_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d.redir", c),  32'(redir_valid_o), 32'd1);
            chk($sformatf("stall%0d.target", c), redir_target_o,     32'h00008010);
            chk($sformatf("stall%0d.ready", c),  32'(br_ready_o),    32'd0);
            chk($sformatf("stall%0d.flush", c),  32'(flush_o),       32'd0);
            pc_plus4_i = 32'hDEAD0000 + 32'(c);           // ignored while busy
            br_valid_i = 1'b1;
            if (c == 4) redir_ready_i = 1'b1;
            @(negedge clk);
        end
        br_valid_i = 1'b0;
        chk("stall.flush",   32'(flush_o),       32'd1);
        chk("stall.redir0",  32'(redir_valid_o), 32'd0);
        chk("stall.resv",    32'(res_valid_o),   32'd0);
        @(negedge clk);
        chk("stall.flush_end", 32'(flush_o),    32'd0);
        chk("stall.ready",     32'(br_ready_o), 32'd1);

        // Reset while in REDIRECT: redirect dropped, no flush
        drive_op(3'b000, 1, 0, 0, 32'h00001000, 16'h0001);
        redir_ready_i = 1'b0;
        @(negedge clk);
        br_valid_i = 1'b0;
        chk("rr.redir_before", 32'(redir_valid_o), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rr.redir", 32'(redir_valid_o), 32'd0);
        chk("rr.ready", 32'(br_ready_o),    32'd1);
        chk("rr.flush", 32'(flush_o),       32'd0);
        redir_ready_i = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rr.flush_after", 32'(flush_o),     32'd0);
        chk("rr.ready_after", 32'(br_ready_o),  32'd1);
        chk("rr.resv_after",  32'(res_valid_o), 32'd0);

`ifdef BRANCH_STATS_EN
        do_reset();
        chk("stat.rst_taken", stat_taken_o,    32'd0);
        run_vec(vecs[0], 0);
        run_vec(vecs[1], 1);
        run_vec(vecs[2], 2);
        run_vec(vecs[3], 3);
        run_vec(vecs[4], 4);
        chk("stat.taken",    stat_taken_o,    32'd3);
        chk("stat.nottaken", stat_nottaken_o, 32'd2);
`else
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
